// File: rtl/mixer_pkg.sv
// Shared types and constants for the mixer LO scheduler: sweep FSM states,
// counter widths and the divider half-period mapping.
package mixer_pkg;
  localparam int LO_SET_W = 3;
  localparam int CNT_W    = 10;
  localparam int GAP_DEF  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_DONE
  } hop_state_e;

  // Half-period in clk cycles for divider setting s; one bit wider than cnt
  // so that the full period 2H (up to 1024) is representable.
  function automatic logic [CNT_W:0] half_period(input logic [LO_SET_W-1:0] s);
    return (CNT_W+1)'(4) << s;
  endfunction
endpackage

// File: rtl/lo_phase_gen.sv
// Free-running LO phase counter with period-boundary detect and the
// non-overlapping lo_p/lo_n decode for the active divider setting.
module lo_phase_gen
  import mixer_pkg::*;
#(
  parameter int GAP = GAP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LO_SET_W-1:0] a,
  output logic                boundary,
  output logic                int_lo_p,
  output logic                int_lo_n
);
  localparam logic [CNT_W:0] GAP_X = (CNT_W+1)'(GAP);
  localparam logic [CNT_W:0] ONE_X = (CNT_W+1)'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   h, cnt_x;

  // a only changes on the wrap edge, so cnt never exceeds 2H-1 for the live a.
  always_comb begin
    h        = half_period(a);
    cnt_x    = {1'b0, cnt_q};
    boundary = (cnt_x == ((h << 1) - ONE_X));
    cnt_d    = boundary ? '0 : cnt_q + 1'b1;
    int_lo_p = (cnt_x >= GAP_X) && (cnt_x < h);
    int_lo_n = (cnt_x >= (h + GAP_X));
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mixer_lo_scheduler.sv
// LO source selection and hop sweep sequencer feeding the Gilbert mixer's
// differential LO pair; setting and source switch only at period boundaries.
module mixer_lo_scheduler
  import mixer_pkg::*;
#(
  parameter int GAP     = GAP_DEF,
  parameter int DWELL_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ext_lo_en,
  input  logic                ext_lo_n,
  input  logic                ext_lo_p,
  input  logic [LO_SET_W-1:0] int_lo_settings,
  input  logic                hop_en,
  input  logic                hop_start,
  input  logic [DWELL_W-1:0]  dwell,
  output logic                lo_p,
  output logic                lo_n,
  output logic [LO_SET_W-1:0] hop_idx,
  output logic                busy,
  output logic                done
);
  hop_state_e          state_q, state_d;
  logic [LO_SET_W-1:0] hop_idx_q, hop_idx_d;
  logic [LO_SET_W-1:0] a_q, a_d;
  logic [DWELL_W-1:0]  pcnt_q, pcnt_d, pcnt_inc;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic                ext_q, ext_d;
  logic                lo_p_q, lo_n_q;
  logic                boundary, int_lo_p, int_lo_n;

  lo_phase_gen #(.GAP(GAP)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .a        (a_q),
    .boundary (boundary),
    .int_lo_p (int_lo_p),
    .int_lo_n (int_lo_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hop_idx_q <= '0;
      pcnt_q    <= '0;
      dwell_q   <= '0;
      a_q       <= '0;
      ext_q     <= 1'b0;
      lo_p_q    <= 1'b0;
      lo_n_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hop_idx_q <= hop_idx_d;
      pcnt_q    <= pcnt_d;
      dwell_q   <= dwell_d;
      a_q       <= a_d;
      ext_q     <= ext_d;
      // Simultaneous external highs collapse to 00 to keep the pair exclusive.
      lo_p_q    <= ext_q ? (ext_lo_p & ~ext_lo_n) : int_lo_p;
      lo_n_q    <= ext_q ? (ext_lo_n & ~ext_lo_p) : int_lo_n;
    end
  end

  always_comb begin
    state_d   = state_q;
    hop_idx_d = hop_idx_q;
    pcnt_d    = pcnt_q;
    dwell_d   = dwell_q;
    pcnt_inc  = pcnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (hop_start && hop_en) begin
          state_d   = S_DWELL;
          hop_idx_d = '0;
          pcnt_d    = '0;
          dwell_d   = (dwell == '0) ? DWELL_W'(1) : dwell;
        end
      end
      S_DWELL: begin
        if (!hop_en) begin
          state_d = S_IDLE;
        end else if (boundary) begin
          if (pcnt_inc == dwell_q) begin
            if (hop_idx_q != '1) begin
              hop_idx_d = hop_idx_q + 1'b1;
              pcnt_d    = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            pcnt_d = pcnt_inc;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Next-state view lets a and hop_idx move on the same boundary edge.
    a_d   = a_q;
    ext_d = ext_q;
    if (boundary) begin
      a_d   = (state_d == S_DWELL) ? hop_idx_d : int_lo_settings;
      ext_d = ext_lo_en;
    end
  end

  always_comb begin
    busy    = (state_q == S_DWELL);
    done    = (state_q == S_DONE);
    hop_idx = hop_idx_q;
    lo_p    = lo_p_q;
    lo_n    = lo_n_q;
  end
endmodule

// File: tb/tb_mixer_lo_scheduler.sv
// Directed bench for mixer_lo_scheduler: vector tables for the LO waveform and
// external mirroring, hand sequences for setting change, sweep, abort and reset.
module tb_mixer_lo_scheduler;
  logic        clk = 1'b0;
  logic        rst, ext_lo_en, ext_lo_n, ext_lo_p, hop_en, hop_start;
  logic [2:0]  int_lo_settings;
  logic [15:0] dwell;
  logic        lo_p, lo_n, busy, done;
  logic [2:0]  hop_idx;

  mixer_lo_scheduler #(.GAP(1), .DWELL_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .ext_lo_en       (ext_lo_en),
    .ext_lo_n        (ext_lo_n),
    .ext_lo_p        (ext_lo_p),
    .int_lo_settings (int_lo_settings),
    .hop_en          (hop_en),
    .hop_start       (hop_start),
    .dwell           (dwell),
    .lo_p            (lo_p),
    .lo_n            (lo_n),
    .hop_idx         (hop_idx),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       p;
    logic       n;
    logic [2:0] set;
    logic       xp;
    logic       xn;
  } vec_t;

  int n_vec = 0, n_bad = 0;
  int done_cnt = 0, ovl_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
    if (lo_p === 1'b1 && lo_n === 1'b1) ovl_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input string name, input vec_t v);
    ext_lo_en = v.en; ext_lo_p = v.p; ext_lo_n = v.n; int_lo_settings = v.set;
    step();
    check({name, ".lo_p"}, {31'd0, lo_p}, {31'd0, v.xp});
    check({name, ".lo_n"}, {31'd0, lo_n}, {31'd0, v.xn});
  endtask

  // Length of the next lo_p high run, bounded.
  task automatic p_run(output int len);
    int t = 0;
    len = 0;
    while (lo_p !== 1'b1 && t < 2000) begin step(); t++; end
    while (lo_p === 1'b1 && t < 2000) begin len++; step(); t++; end
  endtask

  vec_t tab1[$];
  vec_t tab2[$];
  logic [15:0] p_bits, n_bits;
  logic        pa[1:70];
  logic        na[1:70];

  initial begin
    int cp, cn, run1, run2, busy_cycles, first1, first7, doneoff, off3, d0;

    // LO after reset, setting 0: observation k shows decode of cnt = k mod 8.
    p_bits = 16'h0E0E;
    n_bits = 16'hE0E0;
    for (int k = 0; k < 16; k++)
      tab1.push_back('{1'b0, 1'b0, 1'b0, 3'd0, p_bits[k], n_bits[k]});
    // External mode after the boundary: one-flop mirror, 11 forced to 00.
    tab2.push_back('{1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1});
    tab2.push_back('{1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0});
    tab2.push_back('{1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1});
    tab2.push_back('{1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0});
    tab2.push_back('{1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0});
    tab2.push_back('{1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0});
    tab2.push_back('{1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0});

    rst = 1'b1; ext_lo_en = 1'b0; ext_lo_p = 1'b0; ext_lo_n = 1'b0;
    int_lo_settings = 3'd0; hop_en = 1'b0; hop_start = 1'b0; dwell = 16'd0;
    repeat (3) step();
    check("rst.lo_p", {31'd0, lo_p}, 0);
    check("rst.lo_n", {31'd0, lo_n}, 0);
    check("rst.busy", {31'd0, busy}, 0);
    check("rst.done", {31'd0, done}, 0);
    check("rst.hop_idx", {29'd0, hop_idx}, 0);
    rst = 1'b0;

    foreach (tab1[i]) apply($sformatf("wave%0d", i), tab1[i]);

    // Setting 0 -> 3 at cnt = 2: old period completes, then a 64-cycle period.
    repeat (2) step();
    int_lo_settings = 3'd3;
    for (int e = 1; e <= 70; e++) begin
      step();
      pa[e] = lo_p;
      na[e] = lo_n;
    end
    check("chg.old_p_tail", {30'd0, pa[1], pa[2]}, 3);
    check("chg.old_gap", {30'd0, pa[3], na[3]}, 0);
    check("chg.old_n_tail", {29'd0, na[4], na[5], na[6]}, 7);
    check("chg.new_start", {30'd0, pa[7], na[7]}, 0);
    check("chg.new_p_rise", {31'd0, pa[8]}, 1);
    check("chg.p_last", {31'd0, pa[38]}, 1);
    check("chg.mid_gap", {30'd0, pa[39], na[39]}, 0);
    check("chg.n_rise", {31'd0, na[40]}, 1);
    cp = 0; cn = 0;
    for (int e = 7; e <= 70; e++) begin
      if (pa[e] === 1'b1) cp++;
      if (na[e] === 1'b1) cn++;
    end
    check("chg.p_high_cycles", cp, 31);
    check("chg.n_high_cycles", cn, 31);

    // Back to setting 0, then align so the sweep begins at cnt = 0.
    int_lo_settings = 3'd0;
    repeat (64) step();
    repeat (7) step();
    hop_en = 1'b1; hop_start = 1'b1; dwell = 16'd2;
    step();
    hop_start = 1'b0;
    check("sweep.busy_rise", {31'd0, busy}, 1);
    check("sweep.idx0", {29'd0, hop_idx}, 0);
    busy_cycles = 1; first1 = -1; first7 = -1; doneoff = -1;
    for (int off = 1; off <= 5000; off++) begin
      step();
      if (busy === 1'b1) busy_cycles++;
      if (hop_idx == 3'd1 && first1 < 0) first1 = off;
      if (hop_idx == 3'd7 && first7 < 0) first7 = off;
      if (done === 1'b1) begin doneoff = off; break; end
    end
    check("sweep.idx1_at", first1, 16);
    check("sweep.idx7_at", first7, 2032);
    check("sweep.busy_cycles", busy_cycles, 4080);
    check("sweep.done_at", doneoff, 4080);
    step();
    check("sweep.done_single", {31'd0, done}, 0);
    check("sweep.busy_after", {31'd0, busy}, 0);

    // Abort at hop_idx 3 with dwell 0 (treated as 1).
    repeat (6) step();
    dwell = 16'd0; hop_start = 1'b1;
    step();
    hop_start = 1'b0;
    d0 = done_cnt;
    off3 = -1;
    for (int off = 1; off <= 500; off++) begin
      step();
      if (hop_idx == 3'd3) begin off3 = off; break; end
    end
    check("abort.idx3_at", off3, 56);
    hop_en = 1'b0;
    int_lo_settings = 3'd2;
    step();
    check("abort.busy", {31'd0, busy}, 0);
    check("abort.done", {31'd0, done}, 0);
    p_run(run1);
    p_run(run2);
    check("abort.run_old_a3", run1, 31);
    check("abort.run_new_a2", run2, 15);
    check("abort.no_done", done_cnt, d0);

    // External mode: switch request mid-period, effective after the boundary.
    ext_lo_en = 1'b1; ext_lo_p = 1'b1; ext_lo_n = 1'b1;
    step();
    check("ext.pre_boundary_n", {30'd0, lo_p, lo_n}, 1);
    repeat (13) step();
    foreach (tab2[i]) apply($sformatf("ext%0d", i), tab2[i]);

    // Reset mid-sweep with lo_p high.
    ext_lo_en = 1'b0; ext_lo_p = 1'b0; ext_lo_n = 1'b0;
    hop_en = 1'b0; hop_start = 1'b1;
    step();
    hop_start = 1'b0;
    check("start_no_en.busy", {31'd0, busy}, 0);
    hop_en = 1'b1; dwell = 16'd1; hop_start = 1'b1;
    step();
    hop_start = 1'b0;
    check("rst_t.busy", {31'd0, busy}, 1);
    for (int t = 0; t < 2000 && !(hop_idx != 3'd0 && lo_p === 1'b1); t++) step();
    hop_start = 1'b1;
    step();
    hop_start = 1'b0;
    check("restart_ignored.busy", {31'd0, busy}, 1);
    check("restart_ignored.idx_nz", {31'd0, (hop_idx != 3'd0)}, 1);
    for (int t = 0; t < 2000 && lo_p !== 1'b1; t++) step();
    check("rst_t.pre_lo_p", {31'd0, lo_p}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_t.lo", {30'd0, lo_p, lo_n}, 0);
    check("rst_t.busy0", {31'd0, busy}, 0);
    check("rst_t.idx0", {29'd0, hop_idx}, 0);
    hop_start = 1'b1;
    step();
    hop_start = 1'b0;
    check("rst_t.restart", {31'd0, busy}, 1);
    step();
    check("never_overlap", ovl_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
